logicnets_input_packer: RTL

//  Producer side of the layer-0 fan-in interface. Accepts a valid/ready stream of

---
 rtl/logicnets_pkg.sv | 21 ++
 rtl/logicnets_frame_buf.sv | 34 +++
 rtl/logicnets_input_packer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/logicnets_pkg.sv
// Shared types and constants for the LogicNets layer-0 input packer.
package logicnets_pkg;

  localparam int FEAT_W_DEF   = 2;
  localparam int NUM_FEAT_DEF = 32;
  localparam int OUT_W_DEF    = FEAT_W_DEF * NUM_FEAT_DEF;
  localparam int CNT_W_DEF    = $clog2(NUM_FEAT_DEF);

  typedef logic [OUT_W_DEF-1:0] frame_t;

  typedef enum logic {
    FILL      = 1'b0,
    FULL_WAIT = 1'b1
  } fill_state_t;

  // Counter width able to index n distinct values, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/logicnets_frame_buf.sv
// Output frame register with valid/ready hold: data stays stable until taken.
module logicnets_frame_buf #(
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [OUT_W-1:0] in_data,
  input  logic             in_err,
  output logic             in_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_err
);

  // Reload in the same cycle the current frame leaves, so frames go back-to-back.
  assign in_ready = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
    end else if (in_valid && in_ready) begin
      m_valid <= 1'b1;
      m_data  <= in_data;
      m_err   <= in_err;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/logicnets_input_packer.sv
// Packs a valid/ready feature stream into double-buffered frames for the LUT network.
// Optional partial-frame flush on idle is enabled by defining FRAME_TIMEOUT_EN.
module logicnets_input_packer
  import logicnets_pkg::*;
#(
  parameter int FEAT_W      = FEAT_W_DEF,
  parameter int NUM_FEAT    = NUM_FEAT_DEF,
  parameter int OUT_W       = FEAT_W * NUM_FEAT,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_err
);

  localparam int CNT_W = cnt_width(NUM_FEAT);

  fill_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [OUT_W-1:0]  fill_buf;
  logic              pend_err;

  logic              beat;
  logic              last_slot;
  logic              timeout_close;
  logic              close;
  logic              close_err;
  logic [OUT_W-1:0]  write_data;
  logic [OUT_W-1:0]  close_data;

  logic              buf_valid;
  logic              buf_ready;
  logic              buf_err;
  logic [OUT_W-1:0]  buf_data;

  assign s_ready   = (state == FILL);
  assign beat      = s_valid && s_ready;
  assign last_slot = (cnt == CNT_W'(NUM_FEAT - 1));

  always_comb begin
    write_data = fill_buf;
    write_data[int'(cnt)*FEAT_W +: FEAT_W] = s_data;
    close      = (beat && (last_slot || s_last)) || timeout_close;
    // Any frame not ending exactly on the last slot with s_last is malformed.
    close_err  = timeout_close || !(last_slot && s_last);
    close_data = beat ? write_data : fill_buf;
    buf_valid  = (state == FULL_WAIT) || close;
    buf_data   = (state == FULL_WAIT) ? fill_buf : close_data;
    buf_err    = (state == FULL_WAIT) ? pend_err : close_err;
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int IDLE_W = cnt_width(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_close = (state == FILL) && (cnt != '0) && !beat &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (beat || (cnt == '0) || (state != FILL) || timeout_close) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_close = 1'b0;
`endif

  // A closed frame that cannot enter the busy output register parks in fill_buf.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      cnt      <= '0;
      fill_buf <= '0;
      pend_err <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (close) begin
            cnt <= '0;
            if (buf_ready) begin
              fill_buf <= '0;
            end else begin
              fill_buf <= close_data;
              pend_err <= close_err;
              state    <= FULL_WAIT;
            end
          end else if (beat) begin
            fill_buf <= write_data;
            cnt      <= cnt + 1'b1;
          end
        end
        FULL_WAIT: begin
          if (buf_ready) begin
            fill_buf <= '0;
            state    <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  logicnets_frame_buf #(
    .OUT_W (OUT_W)
  ) u_frame_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (buf_valid),
    .in_data  (buf_data),
    .in_err   (buf_err),
    .in_ready (buf_ready),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_err    (m_err)
  );

endmodule
